// File: rtl/multi_adc_rx_core.sv
// Generic first-word-fall-through FIFO; head word visible combinationally, reads 0 when empty.
// Latency: a write at cycle t is visible at t+1. Backpressure: wr_rdy_o low when full with no pop.
module multi_adc_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             wr_rdy_o,
    input  logic             rd_rdy_i,
    output logic             rd_vld_o,
    output logic [WIDTH-1:0] rd_dat_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             full;
    logic             push;
    logic             pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign rd_vld_o = (cnt_q != '0);
    assign pop      = rd_rdy_i && rd_vld_o;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_rdy_o = !full || pop;
    assign push     = wr_vld_i && wr_rdy_o;
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// Multi-channel ADC capture: arm/sync/trigger FSM, per-frame serialiser into tagged words, FWFT FIFO.
// Latency: k-th enabled word of a frame strobed at t is pushed at t+k. Backpressure: none upstream;
// frames arriving while the serialiser is busy and words hitting a full FIFO are dropped and counted.
module multi_adc_rx_core #(
    parameter int         NCH       = 4,
    parameter int         ADC_WIDTH = 14,
    parameter int         DEPTH     = 1024,
    parameter logic [3:0] HEADER_ID = 4'd0
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic                     ADC_CE,
    input  logic [NCH*ADC_WIDTH-1:0] ADC_IN,
    input  logic                     ADC_SYNC,
    input  logic                     ADC_TRIGGER,
    input  logic                     CONF_START,
    input  logic                     CONF_ABORT,
    input  logic                     CONF_EN_SYNC,
    input  logic                     CONF_EN_TRIG,
    input  logic [23:0]              CONF_SAMPLES,
    input  logic [NCH-1:0]           CONF_CH_MASK,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [7:0]               LOST_COUNT,
    input  logic                     FIFO_READ,
    output logic                     FIFO_EMPTY,
    output logic [31:0]              FIFO_DATA
);
    localparam logic [1:0]     ST_IDLE    = 2'd0;
    localparam logic [1:0]     ST_ARMED   = 2'd1;
    localparam logic [1:0]     ST_CAPTURE = 2'd2;
    localparam logic [NCH-1:0] CH_ONE     = NCH'(1);

    logic [1:0]               state_q, state_d;
    logic                     done_q, done_d;
    logic [7:0]               lost_q, lost_d;
    logic [23:0]              frame_q, frame_d;
    logic                     sync_q, sync_prev_q;
    logic                     trig_q, trig_prev_q;
    logic [NCH*ADC_WIDTH-1:0] shadow_q;
    logic [23:0]              sh_frame_q;
    logic [NCH-1:0]           pend_q, pend_d;

    logic        busy;
    logic        sync_edge, trig_edge;
    logic        frame_ce, ser_last, ser_ready;
    logic        frame_acc, frame_lost;
    logic        push_vld, push_rdy, word_drop, fifo_vld;
    logic [1:0]  ch_idx;
    logic [15:0] samp_ext;
    logic [31:0] word;
    logic [8:0]  lost_sum;
    logic [23:0] frame_inc;

    assign busy      = (state_q != ST_IDLE);
    assign sync_edge = sync_q && !sync_prev_q && CONF_EN_SYNC;
    assign trig_edge = trig_q && !trig_prev_q && CONF_EN_TRIG;
    assign frame_ce  = (state_q == ST_CAPTURE) && ADC_CE && !CONF_ABORT;
    assign ser_last  = (pend_q != '0) && ((pend_q & (pend_q - CH_ONE)) == '0);
    assign ser_ready = (pend_q == '0) || ser_last;
    assign frame_acc  = frame_ce && ser_ready;
    assign frame_lost = frame_ce && !ser_ready;
    assign push_vld   = (pend_q != '0);
    assign word_drop  = push_vld && !push_rdy;
    assign frame_inc  = frame_q + 24'd1;
    assign lost_sum   = {1'b0, lost_q} + 9'(frame_lost) + 9'(word_drop);

    // Serialiser emits the lowest pending channel first.
    always_comb begin
        ch_idx   = '0;
        samp_ext = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (pend_q[c]) begin
                ch_idx                   = 2'(c);
                samp_ext[ADC_WIDTH-1:0]  = shadow_q[c*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

    assign word = {HEADER_ID, ch_idx, (sh_frame_q == 24'd0), sh_frame_q[8:0], samp_ext};

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        frame_d = frame_q;
        lost_d  = lost_sum[8] ? 8'hFF : lost_sum[7:0];
        case (state_q)
            ST_IDLE: begin
                if (CONF_START && (CONF_CH_MASK != '0)) begin
                    state_d = (CONF_EN_SYNC || CONF_EN_TRIG) ? ST_ARMED : ST_CAPTURE;
                    done_d  = 1'b0;
                    lost_d  = '0;
                    frame_d = '0;
                end
            end
            ST_ARMED: begin
                if (CONF_ABORT) begin
                    state_d = ST_IDLE;
                end else if (sync_edge || trig_edge) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (CONF_ABORT) begin
                    state_d = ST_IDLE;
                end else if (ADC_CE) begin
                    frame_d = frame_inc;
                    if ((CONF_SAMPLES != 24'd0) && (frame_inc == CONF_SAMPLES)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (busy && CONF_ABORT) begin
            pend_d = '0;
        end else if (frame_acc) begin
            pend_d = CONF_CH_MASK;
        end else begin
            pend_d = pend_q & (pend_q - CH_ONE);
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            lost_q      <= '0;
            frame_q     <= '0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            trig_q      <= 1'b0;
            trig_prev_q <= 1'b0;
            shadow_q    <= '0;
            sh_frame_q  <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            lost_q      <= lost_d;
            frame_q     <= frame_d;
            sync_q      <= ADC_SYNC;
            sync_prev_q <= sync_q;
            trig_q      <= ADC_TRIGGER;
            trig_prev_q <= trig_q;
            pend_q      <= pend_d;
            if (frame_acc) begin
                shadow_q   <= ADC_IN;
                sh_frame_q <= frame_q;
            end
        end
    end

    multi_adc_rx_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (BUS_CLK),
        .rst_i    (BUS_RST),
        .wr_vld_i (push_vld),
        .wr_dat_i (word),
        .wr_rdy_o (push_rdy),
        .rd_rdy_i (FIFO_READ),
        .rd_vld_o (fifo_vld),
        .rd_dat_o (FIFO_DATA)
    );

    assign BUSY       = busy;
    assign DONE       = done_q;
    assign LOST_COUNT = lost_q;
    assign FIFO_EMPTY = !fifo_vld;
endmodule
